data_memory_responder: RTL and testbench

Multi-cycle responder for the data-memory interface driven by the pipeline's memory stage. It accepts one word read or write request at a time over a valid/ready handshake and inserts a fixed number of wait states. It returns read data, or write completion, with a one-cycle response pulse. While a request is outstanding it drives a stall signal so the pipeline holds the memory stage. It replaces the zero-wait data memory with a slower, more realistic timing model.

---
 rtl/data_memory_responder.sv | 119 +++++++++++
 tb/tb_data_memory_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder: accepts one word load/store at a time,
// inserts WAIT_CYCLES wait states, then pulses a registered response.
module data_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        requestValid,
  input  logic        requestWrite,
  input  logic [31:0] requestAddress,
  input  logic [31:0] requestWriteData,
  output logic        requestReady,
  output logic        responseValid,
  output logic [31:0] responseData,
  output logic        responseError,
  output logic        stall
);

  localparam int unsigned LAT_WIDTH = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                 state;
  logic [3:0]             count;
  logic                   lat_write;
  logic [LAT_WIDTH-1:0]   lat_addr;
  logic [31:0]            lat_data;
  logic [31:0]            mem [DEPTH];

  logic                   commit;
  logic                   acc_write;
  logic [LAT_WIDTH-1:0]   acc_addr;
  logic [31:0]            acc_data;
  logic                   acc_error;
  logic [ADDR_WIDTH-1:0]  acc_index;

  // Address bits above the word index wrap and are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^requestAddress[31:LAT_WIDTH];

  // Select the access that commits at this edge: live inputs when a zero-wait
  // request is accepted straight from IDLE, otherwise the latched request.
  always_comb begin
    commit    = 1'b0;
    acc_write = lat_write;
    acc_addr  = lat_addr;
    acc_data  = lat_data;
    if (state == S_IDLE) begin
      acc_write = requestWrite;
      acc_addr  = requestAddress[LAT_WIDTH-1:0];
      acc_data  = requestWriteData;
      commit    = requestValid && (WAIT_CYCLES == 0);
    end else if (state == S_WAIT) begin
      commit = (count == 4'd0);
    end
  end

  assign acc_error    = (acc_addr[1:0] != 2'b00);
  assign acc_index    = acc_addr[LAT_WIDTH-1:2];
  assign requestReady = (state == S_IDLE) && !reset;
  assign stall        = requestValid && !responseValid;

  // Control FSM with registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= 4'd0;
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_data      <= 32'd0;
      responseValid <= 1'b0;
      responseData  <= 32'd0;
      responseError <= 1'b0;
    end else begin
      responseValid <= 1'b0;
      if (commit) begin
        responseValid <= 1'b1;
        responseError <= acc_error;
        responseData  <= (acc_write || acc_error) ? 32'd0 : mem[acc_index];
      end
      case (state)
        S_IDLE: begin
          if (requestValid) begin
            lat_write <= requestWrite;
            lat_addr  <= requestAddress[LAT_WIDTH-1:0];
            lat_data  <= requestWriteData;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESPOND;
            end else begin
              state <= S_WAIT;
              count <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (count == 4'd0) state <= S_RESPOND;
          else               count <= count - 4'd1;
        end
        S_RESPOND: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset; a store pending when reset arrives is dropped.
  always_ff @(posedge clock) begin
    if (!reset && commit && acc_write && !acc_error) begin
      mem[acc_index] <= acc_data;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states,
// one with zero wait states.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        v, w, v0, w0;
  logic [31:0] a, d, a0, d0;
  logic        rdy, rv, re, st, rdy0, rv0, re0, st0;
  logic [31:0] rd, rd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clock(clk), .reset(reset),
    .requestValid(v), .requestWrite(w), .requestAddress(a), .requestWriteData(d),
    .requestReady(rdy), .responseValid(rv), .responseData(rd),
    .responseError(re), .stall(st)
  );

  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset(reset),
    .requestValid(v0), .requestWrite(w0), .requestAddress(a0), .requestWriteData(d0),
    .requestReady(rdy0), .responseValid(rv0), .responseData(rd0),
    .responseError(re0), .stall(st0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request (sel=1 targets the zero-wait instance) and hold it
  // until the response; lat counts cycles from acceptance to response.
  task automatic xact(input bit sel, input logic wr, input logic [31:0] ad, input logic [31:0] dt,
                      output int lat, output int stalls, output logic [31:0] data, output logic err);
    if (sel) begin v0 = 1'b1; w0 = wr; a0 = ad; d0 = dt; end
    else     begin v  = 1'b1; w  = wr; a  = ad; d  = dt; end
    lat = 0; stalls = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (sel ? st0 : st) stalls++;
      if (sel ? rv0 : rv) break;
      @(posedge clk);
      #1;
      lat++;
    end
    data = sel ? rd0 : rd;
    err  = sel ? re0 : re;
    v = 1'b0; v0 = 1'b0;
    tick();
  endtask

  int          lat, stalls, pulses;
  logic [31:0] data;
  logic        err;

  initial begin
    reset = 1'b1;
    v = 0; w = 0; a = 0; d = 0;
    v0 = 0; w0 = 0; a0 = 0; d0 = 0;
    tick(); tick();
    chk("ready_in_reset", 32'(rdy), 32'd0);
    chk("ready0_in_reset", 32'(rdy0), 32'd0);
    chk("rv_reset", 32'(rv), 32'd0);
    chk("rd_reset", rd, 32'd0);
    chk("re_reset", 32'(re), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 32'(rdy), 32'd1);
    tick();

    // Store then load, two wait states
    xact(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, stalls, data, err);
    chk("store_latency", 32'(lat), 32'd3);
    chk("store_stalls", 32'(stalls), 32'd3);
    chk("store_data", data, 32'd0);
    chk("store_err", 32'(err), 32'd0);
    xact(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, stalls, data, err);
    chk("load_latency", 32'(lat), 32'd3);
    chk("load_data", data, 32'hDEAD_BEEF);

    // Misaligned store is rejected and does not write
    xact(1'b0, 1'b1, 32'h0000_0012, 32'h1234_5678, lat, stalls, data, err);
    chk("misaligned_err", 32'(err), 32'd1);
    chk("misaligned_data", data, 32'd0);
    xact(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, stalls, data, err);
    chk("after_misaligned_load", data, 32'hDEAD_BEEF);
    chk("after_misaligned_err", 32'(err), 32'd0);

    // Address wrap
    xact(1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, lat, stalls, data, err);
    xact(1'b0, 1'b0, 32'h0000_0004, 32'h0, lat, stalls, data, err);
    chk("wrap_load", data, 32'hA5A5_A5A5);

    // Reset at the commit edge of a pending store
    xact(1'b0, 1'b1, 32'h0000_0020, 32'h2222_2222, lat, stalls, data, err);
    v = 1'b1; w = 1'b1; a = 32'h0000_0020; d = 32'h1111_1111;
    tick();
    chk("ready_wait1", 32'(rdy), 32'd0);
    tick();
    chk("ready_wait2", 32'(rdy), 32'd0);
    reset = 1'b1;
    tick();
    chk("rv_after_reset_wait", 32'(rv), 32'd0);
    reset = 1'b0; v = 1'b0;
    #1;
    chk("ready_after_reset_wait", 32'(rdy), 32'd1);
    tick();
    chk("rv_no_pulse", 32'(rv), 32'd0);
    xact(1'b0, 1'b0, 32'h0000_0020, 32'h0, lat, stalls, data, err);
    chk("discarded_store", data, 32'h2222_2222);

    // Address change while busy is ignored
    v = 1'b1; w = 1'b0; a = 32'h0000_0010; d = 32'h0;
    tick();
    chk("busy_ready_w", 32'(rdy), 32'd0);
    a = 32'h0000_0004;
    tick();
    tick();
    chk("busy_rv", 32'(rv), 32'd1);
    chk("busy_ready_r", 32'(rdy), 32'd0);
    chk("busy_stall_r", 32'(st), 32'd0);
    chk("busy_data", rd, 32'hDEAD_BEEF);
    v = 1'b0;
    tick();
    chk("post_rv", 32'(rv), 32'd0);
    chk("post_ready", 32'(rdy), 32'd1);
    chk("post_hold", rd, 32'hDEAD_BEEF);

    // Zero wait states
    xact(1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, lat, stalls, data, err);
    chk("w0_store_latency", 32'(lat), 32'd1);
    chk("w0_store_stalls", 32'(stalls), 32'd1);
    xact(1'b1, 1'b0, 32'h0000_0008, 32'h0, lat, stalls, data, err);
    chk("w0_load_latency", 32'(lat), 32'd1);
    chk("w0_load_stalls", 32'(stalls), 32'd1);
    chk("w0_load_data", data, 32'hCAFE_F00D);

    // Back-to-back loads with valid held: one response every two cycles
    v0 = 1'b1; w0 = 1'b0; a0 = 32'h0000_0008;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rv0) begin
        pulses++;
        chk("w0_b2b_data", rd0, 32'hCAFE_F00D);
      end
      @(posedge clk);
    end
    #1;
    v0 = 1'b0;
    chk("w0_b2b_pulses", 32'(pulses), 32'd4);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
